// File: rtl/seq_restoring_divider.sv
// Multi-cycle unsigned restoring divider: one trial subtraction per clock,
// start/busy/done handshake, results held until the next completed operation.
module seq_restoring_divider #(
    parameter int N = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] dividend,
    input  logic [N-1:0] divisor,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] quotient,
    output logic [N-1:0] remainder,
    output logic         div_by_zero_flag,
    output logic         zero_flag,
    output logic [1:0]   dbg_state
);

    // Handshake: start is accepted only in IDLE; busy is high for the N RUN
    // cycles; done is a one-cycle pulse, after which the next start may land.
    localparam int CW = (N > 2) ? $clog2(N) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t         state, state_nx;
    logic [CW-1:0]  cnt, cnt_nx;
    logic [N-1:0]   q_reg, q_nx;
    logic [N-1:0]   d_reg, d_nx;
    logic [N-1:0]   r_reg, r_nx;
    logic [N-1:0]   quo_nx, rem_nx;
    logic           dbz_nx, zero_nx;

    logic [N:0]     r_shift;
    logic [N:0]     trial;
    logic [N-1:0]   q_shift;
    logic [N-1:0]   r_iter;

    // The partial remainder stays below the divisor, so N bits hold it; only
    // the shifted value needs the extra bit before the trial subtraction.
    always_comb begin
        r_shift = {r_reg, q_reg[N-1]};
        trial   = r_shift - {1'b0, d_reg};
        q_shift = {q_reg[N-2:0], ~trial[N]};
        r_iter  = trial[N] ? r_shift[N-1:0] : trial[N-1:0];
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        q_nx     = q_reg;
        d_nx     = d_reg;
        r_nx     = r_reg;
        quo_nx   = quotient;
        rem_nx   = remainder;
        dbz_nx   = div_by_zero_flag;
        zero_nx  = zero_flag;
        case (state)
            IDLE: begin
                if (start) begin
                    q_nx   = dividend;
                    d_nx   = divisor;
                    r_nx   = '0;
                    cnt_nx = '0;
                    if (divisor != '0) begin
                        state_nx = RUN;
                    end else begin
                        state_nx = DONE;
                        quo_nx   = '1;
                        rem_nx   = dividend;
                        dbz_nx   = 1'b1;
                        zero_nx  = 1'b0;
                    end
                end
            end
            RUN: begin
                q_nx   = q_shift;
                r_nx   = r_iter;
                cnt_nx = cnt + CW'(1);
                if (cnt == CW'(N - 1)) begin
                    state_nx = DONE;
                    quo_nx   = q_shift;
                    rem_nx   = r_iter;
                    dbz_nx   = 1'b0;
                    zero_nx  = (q_shift == '0);
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state            <= IDLE;
            cnt              <= '0;
            q_reg            <= '0;
            d_reg            <= '0;
            r_reg            <= '0;
            quotient         <= '0;
            remainder        <= '0;
            div_by_zero_flag <= 1'b0;
            zero_flag        <= 1'b0;
        end else begin
            state            <= state_nx;
            cnt              <= cnt_nx;
            q_reg            <= q_nx;
            d_reg            <= d_nx;
            r_reg            <= r_nx;
            quotient         <= quo_nx;
            remainder        <= rem_nx;
            div_by_zero_flag <= dbz_nx;
            zero_flag        <= zero_nx;
        end
    end

    assign busy      = (state == RUN);
    assign done      = (state == DONE);
    assign dbg_state = state;

endmodule
